secure_read_fifo: RTL and testbench



---
 rtl/secure_read_fifo.sv | 89 ++++++++
 tb/tb_secure_read_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/secure_read_fifo.sv
// rtl/secure_read_fifo.sv - FIFO for sensitive bytes; zeroizes slots on read and on clear.
module secure_read_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       clear_req,
    output logic                       clear_busy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ACTIVE = 1'b0,
        SCRUB  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_idx;
    logic [CW-1:0]        r_count;
    logic                 w_open;
    logic                 w_push;
    logic                 w_pop;

    // A pending clear closes both ports in the same cycle it is seen.
    assign w_open     = (r_state == ACTIVE) && !clear_req;
    assign wr_ready   = w_open && (r_count < CW'(DEPTH));
    assign rd_valid   = w_open && (r_count != '0);
    assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign clear_busy = (r_state == SCRUB);
    assign count      = r_count;
    assign w_push     = wr_valid && wr_ready;
    assign w_pop      = rd_valid && rd_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACTIVE: if (clear_req) w_state_next = SCRUB;
            SCRUB:  if (r_idx == AW'(DEPTH - 1)) w_state_next = ACTIVE;
            default: w_state_next = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ACTIVE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_idx    <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == SCRUB) begin
                r_mem[r_idx] <= '0;
                r_idx        <= r_idx + AW'(1);
            end else if (clear_req) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_idx    <= '0;
                r_count  <= '0;
            end else begin
                // Push and pop never address the same slot: that needs 0 < count < DEPTH.
                if (w_pop) begin
                    r_mem[r_rd_ptr] <= '0;
                    r_rd_ptr        <= r_rd_ptr + AW'(1);
                end
                if (w_push) begin
                    r_mem[r_wr_ptr] <= wr_data;
                    r_wr_ptr        <= r_wr_ptr + AW'(1);
                end
                if (w_push && !w_pop) r_count <= r_count + CW'(1);
                else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_secure_read_fifo.sv
// tb/tb_secure_read_fifo.sv - scoreboard bench for secure_read_fifo.
module tb_secure_read_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             clear_req;
    logic             clear_busy;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];
    int scrub_left = 0;
    int m_rd = 0;
    int m_wr = 0;

    secure_read_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .clear_req(clear_req), .clear_busy(clear_busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic exp_wr_ready;
        logic exp_rd_valid;
        logic [WIDTH-1:0] popped;
        @(negedge clk);
        if (!rst) begin
            exp_wr_ready = (scrub_left == 0) && !clear_req && (q.size() < DEPTH);
            exp_rd_valid = (scrub_left == 0) && !clear_req && (q.size() > 0);
            chk("wr_ready", 32'(wr_ready), 32'(exp_wr_ready));
            chk("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
            chk("clear_busy", 32'(clear_busy), 32'(scrub_left != 0));
            chk("count", 32'(count), 32'(q.size()));
            chk("rd_data", 32'(rd_data), exp_rd_valid ? 32'(q[0]) : 32'h0);
            if (scrub_left == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    int k;
                    k = (i - m_rd + DEPTH) % DEPTH;
                    if (k < q.size()) chk("mem_live", 32'(dut.r_mem[i]), 32'(q[k]));
                    else chk("mem_zero", 32'(dut.r_mem[i]), 32'h0);
                end
            end
            if (scrub_left > 0) begin
                scrub_left--;
            end else if (clear_req) begin
                scrub_left = DEPTH;
                q.delete();
                m_rd = 0;
                m_wr = 0;
            end else begin
                if (exp_rd_valid && rd_ready) begin
                    popped = q.pop_front();
                    m_rd = (m_rd + 1) % DEPTH;
                end
                if (exp_wr_ready && wr_valid) begin
                    q.push_back(wr_data);
                    m_wr = (m_wr + 1) % DEPTH;
                end
            end
        end else begin
            q.delete();
            scrub_left = 0;
            m_rd = 0;
            m_wr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; clear_req = 1'b0;
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();

        wr_valid = 1'b1; wr_data = 8'hA5; cycle();
        wr_data = 8'h3C; cycle();
        wr_valid = 1'b0; cycle();
        chk("dir_count2", 32'(count), 32'd2);
        chk("dir_head_a5", 32'(rd_data), 32'hA5);
        rd_ready = 1'b1; cycle();
        rd_ready = 1'b0; cycle();
        chk("dir_head_3c", 32'(rd_data), 32'h3C);
        rd_ready = 1'b1; cycle();
        rd_ready = 1'b0; cycle();
        chk("dir_empty_data", 32'(rd_data), 32'h0);

        wr_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_data = 8'(i * 8'h11);
            cycle();
        end
        wr_data = 8'h55; cycle();
        chk("dir_full_ready", 32'(wr_ready), 32'h0);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'(8'h55 + i * 8'h11);
            cycle();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        rd_ready = 1'b0;

        wr_valid = 1'b1; wr_data = 8'hFF;
        for (int i = 0; i < 3; i++) cycle();
        wr_valid = 1'b0; clear_req = 1'b1; cycle();
        clear_req = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) cycle();

        wr_valid = 1'b1; wr_data = 8'h5A; cycle();
        rd_ready = 1'b1; wr_data = 8'h6B; clear_req = 1'b1; cycle();
        clear_req = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        chk("dir_post_rst_busy", 32'(clear_busy), 32'h0);

        for (int n = 0; n < 400; n++) begin
            wr_valid  = ($urandom_range(0, 2) != 0);
            wr_data   = 8'($urandom_range(1, 255));
            rd_ready  = ($urandom_range(0, 2) != 0);
            clear_req = ($urandom_range(0, 24) == 0);
            cycle();
        end
        wr_valid = 1'b0; clear_req = 1'b0; rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 6; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
